// File: rtl/ch_trigger_capture_if.sv
// ch_trigger_capture_if: trigger/readout bus between the capture block and its environment; CH_TRIG_OVERFLOW_CNT_EN adds overflow_cnt.
interface ch_trigger_capture_if #(
  parameter int CNT_W = 10
);
  logic TRIG;
  logic ARM;
  logic READOUT_REQ;
  logic [2:0] trigger_cnt;
  logic [CNT_W-1:0] CA, CB, CC, CD, CE;
  logic INST_READOUT;
  logic BUSY;
`ifdef CH_TRIG_OVERFLOW_CNT_EN
  logic [7:0] overflow_cnt;
`endif
  modport master (
    output TRIG, ARM, READOUT_REQ,
    input trigger_cnt, CA, CB, CC, CD, CE, INST_READOUT, BUSY
`ifdef CH_TRIG_OVERFLOW_CNT_EN
    , overflow_cnt
`endif
  );
  modport slave (
    input TRIG, ARM, READOUT_REQ,
    output trigger_cnt, CA, CB, CC, CD, CE, INST_READOUT, BUSY
`ifdef CH_TRIG_OVERFLOW_CNT_EN
    , overflow_cnt
`endif
  );
endinterface

// File: rtl/ch_trigger_capture.sv
// ch_trigger_capture: per-channel trigger timestamp capture into 5 slots with snapshot strobe; CH_TRIG_OVERFLOW_CNT_EN adds overflow_cnt.
module ch_trigger_capture #(
  parameter int CNT_W = 10,
  parameter int SYNC_STAGES = 2,
  parameter int RD_PULSE_CYCLES = 4
) (
  input logic CLK,
  input logic RST,
  ch_trigger_capture_if.slave bus
);
  localparam int PW = $clog2(RD_PULSE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARMED, READOUT, CLEAR} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic sync_prev_q;
  logic ev;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] tcnt_q, tcnt_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] slot_q [5];
  logic [CNT_W-1:0] slot_d [5];
  logic rd_q, busy_q;
  assign ev = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tcnt_d = tcnt_q;
    pc_d = pc_q;
    slot_d = slot_q;
    case (state_q)
      IDLE: begin
        if (bus.READOUT_REQ) begin
          state_d = READOUT;
          pc_d = '0;
        end else if (bus.ARM) begin
          state_d = ARMED;
          cnt_d = '0;
        end
      end
      ARMED: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ev && tcnt_q < 3'd5) begin
          slot_d[tcnt_q] = cnt_q;
          tcnt_d = tcnt_q + 3'd1;
        end
        if (bus.READOUT_REQ) begin
          state_d = READOUT;
          pc_d = '0;
        end else if (!bus.ARM) state_d = IDLE;
      end
      READOUT: begin
        pc_d = pc_q + PW'(1);
        if (pc_q == PW'(RD_PULSE_CYCLES - 1)) state_d = CLEAR;
      end
      CLEAR: begin
        slot_d = '{default: '0};
        tcnt_d = '0;
        cnt_d = '0;
        state_d = bus.ARM ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // strobe and busy are registered from the next state so they align with it and never glitch
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      sync_prev_q <= 1'b0;
      cnt_q <= '0;
      tcnt_q <= '0;
      pc_q <= '0;
      slot_q <= '{default: '0};
      rd_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.TRIG};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q <= cnt_d;
      tcnt_q <= tcnt_d;
      pc_q <= pc_d;
      slot_q <= slot_d;
      rd_q <= state_d == READOUT;
      busy_q <= state_d == READOUT || state_d == CLEAR;
    end
  end
`ifdef CH_TRIG_OVERFLOW_CNT_EN
  logic [7:0] ovf_q, ovf_d;
  assign ovf_d = state_q == CLEAR ? 8'd0 :
                 (state_q == ARMED && ev && tcnt_q == 3'd5 && ovf_q != 8'hff) ? ovf_q + 8'd1 : ovf_q;
  always_ff @(posedge CLK) ovf_q <= RST ? 8'd0 : ovf_d;
  assign bus.overflow_cnt = ovf_q;
`else
`endif
  assign bus.trigger_cnt = tcnt_q;
  assign bus.CA = slot_q[0];
  assign bus.CB = slot_q[1];
  assign bus.CC = slot_q[2];
  assign bus.CD = slot_q[3];
  assign bus.CE = slot_q[4];
  assign bus.INST_READOUT = rd_q;
  assign bus.BUSY = busy_q;
endmodule
